// File: rtl/sprind_pkg.sv
// Shared types for the SPRIND writeback and branch logic: condition codes,
// the flags record and the default datapath width.
package sprind_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_CS = 4'd3,
    COND_CC = 4'd4,
    COND_MI = 4'd5,
    COND_PL = 4'd6,
    COND_VS = 4'd7,
    COND_VC = 4'd8,
    COND_HI = 4'd9,
    COND_LS = 4'd10,
    COND_GE = 4'd11,
    COND_LT = 4'd12,
    COND_GT = 4'd13,
    COND_LE = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic s;
  } flags_t;

endpackage

// File: rtl/sprind_cond_eval.sv
// Combinational branch-condition evaluator: flags plus condition code to a
// single taken/not-taken bit. Shared with the branch unit.
module sprind_cond_eval
  import sprind_pkg::*;
(
  input  flags_t i_flags,
  input  cond_e  i_cond,
  output logic   o_true
);

  always_comb begin
    o_true = 1'b0;
    case (i_cond)
      COND_AL: o_true = 1'b1;
      COND_EQ: o_true = i_flags.z;
      COND_NE: o_true = !i_flags.z;
      COND_CS: o_true = i_flags.c;
      COND_CC: o_true = !i_flags.c;
      COND_MI: o_true = i_flags.s;
      COND_PL: o_true = !i_flags.s;
      COND_VS: o_true = i_flags.v;
      COND_VC: o_true = !i_flags.v;
      COND_HI: o_true = i_flags.c && !i_flags.z;
      COND_LS: o_true = !i_flags.c || i_flags.z;
      COND_GE: o_true = (i_flags.s == i_flags.v);
      COND_LT: o_true = (i_flags.s != i_flags.v);
      COND_GT: o_true = !i_flags.z && (i_flags.s == i_flags.v);
      COND_LE: o_true = i_flags.z || (i_flags.s != i_flags.v);
      COND_NV: o_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/sprind_writeback.sv
// SPRIND writeback stage: one-entry W1 latch, inline register file and flags
// register, fully bypassed read ports, condition evaluation, retire counter.
module sprind_writeback #(
  parameter  int DATA_W   = sprind_pkg::DATA_W,
  parameter  int NUM_REGS = 8,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wb_valid,
  input  logic [AW-1:0]     i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_result,
  input  logic              i_wb_flags_we,
  input  logic              i_carry,
  input  logic              i_overflow,
  input  logic              i_zero,
  input  logic              i_sign,
  input  logic              i_flush,
  input  logic [AW-1:0]     i_rs_addr,
  input  logic [AW-1:0]     i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  input  logic [3:0]        i_cond,
  output logic              o_cond_true,
  output logic [3:0]        o_flags,
  output logic [15:0]       o_retired
);

  import sprind_pkg::*;

  logic              r_w1_valid;
  logic [AW-1:0]     r_w1_rd;
  logic [DATA_W-1:0] r_w1_result;
  logic              r_w1_flags_we;
  flags_t            r_w1_flags;

  flags_t            r_flags;
  logic [15:0]       r_retired;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_commit;
  flags_t            w_in_flags;
  flags_t            w_cond_flags;

  assign w_commit   = r_w1_valid && !i_flush;
  assign w_in_flags = '{c: i_carry, v: i_overflow, z: i_zero, s: i_sign};

  // W1 latch: valid bit is reset-cleared, payload is plain data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_w1_valid <= 1'b0;
    else        r_w1_valid <= i_wb_valid;
  end

  always_ff @(posedge clk) begin
    if (i_wb_valid) begin
      r_w1_rd       <= i_wb_rd;
      r_w1_result   <= i_wb_result;
      r_w1_flags_we <= i_wb_flags_we;
      r_w1_flags    <= w_in_flags;
    end
  end

  // Commit: register 0 is never written but still counts as retired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_flags   <= '0;
      r_retired <= '0;
    end else if (w_commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (r_w1_rd == AW'(i)) r_regs[i] <= r_w1_result;
      end
      if (r_w1_flags_we) r_flags <= r_w1_flags;
      r_retired <= r_retired + 16'd1;
    end
  end

  always_comb begin
    o_rs_data = r_regs[i_rs_addr];
    if (i_rs_addr == '0)                          o_rs_data = '0;
    else if (i_wb_valid && i_wb_rd == i_rs_addr)  o_rs_data = i_wb_result;
    else if (w_commit && r_w1_rd == i_rs_addr)    o_rs_data = r_w1_result;
  end

  always_comb begin
    o_rt_data = r_regs[i_rt_addr];
    if (i_rt_addr == '0)                          o_rt_data = '0;
    else if (i_wb_valid && i_wb_rd == i_rt_addr)  o_rt_data = i_wb_result;
    else if (w_commit && r_w1_rd == i_rt_addr)    o_rt_data = r_w1_result;
  end

  // Pending flags are visible to branches only while they are still going to commit
  assign w_cond_flags = (w_commit && r_w1_flags_we) ? r_w1_flags : r_flags;

  sprind_cond_eval u_cond_eval (
    .i_flags (w_cond_flags),
    .i_cond  (cond_e'(i_cond)),
    .o_true  (o_cond_true)
  );

  assign o_flags   = r_flags;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_sprind_writeback.sv
// Randomised and directed bench for sprind_writeback against a cycle-level
// behavioural model of the register file, flags and retire counter.
module tb_sprind_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_wb_valid = 1'b0;
  logic [2:0]  i_wb_rd = '0;
  logic [15:0] i_wb_result = '0;
  logic        i_wb_flags_we = 1'b0;
  logic        i_carry = 1'b0, i_overflow = 1'b0, i_zero = 1'b0, i_sign = 1'b0;
  logic        i_flush = 1'b0;
  logic [2:0]  i_rs_addr = '0, i_rt_addr = '0;
  logic [15:0] o_rs_data, o_rt_data;
  logic [3:0]  i_cond = '0;
  logic        o_cond_true;
  logic [3:0]  o_flags;
  logic [15:0] o_retired;

  int n_checks = 0;
  int n_errors = 0;

  sprind_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wb_valid   (i_wb_valid),
    .i_wb_rd      (i_wb_rd),
    .i_wb_result  (i_wb_result),
    .i_wb_flags_we(i_wb_flags_we),
    .i_carry      (i_carry),
    .i_overflow   (i_overflow),
    .i_zero       (i_zero),
    .i_sign       (i_sign),
    .i_flush      (i_flush),
    .i_rs_addr    (i_rs_addr),
    .i_rt_addr    (i_rt_addr),
    .o_rs_data    (o_rs_data),
    .o_rt_data    (o_rt_data),
    .i_cond       (i_cond),
    .o_cond_true  (o_cond_true),
    .o_flags      (o_flags),
    .o_retired    (o_retired)
  );

  always #5 clk = ~clk;

  // Model state: architectural registers, flags, counter and one pending result
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;
  logic [15:0] m_retired;
  logic        m_pv;
  logic [2:0]  m_prd;
  logic [15:0] m_pres;
  logic        m_pfwe;
  logic [3:0]  m_pfl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0; m_retired = '0; m_pv = 1'b0;
    m_prd = '0; m_pres = '0; m_pfwe = 1'b0; m_pfl = '0;
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (i_wb_valid && i_wb_rd == a) return i_wb_result;
    if (m_pv && !i_flush && m_prd == a) return m_pres;
    return m_regs[a];
  endfunction

  // Conditions come in complementary pairs (1/2, 3/4, ... 13/14) plus AL/NV
  function automatic logic m_cond(input logic [3:0] f, input logic [3:0] code);
    logic c, v, z, s, base;
    int idx;
    {c, v, z, s} = f;
    if (code == 4'd0)  return 1'b1;
    if (code == 4'd15) return 1'b0;
    idx = (int'(code) + 1) / 2;
    case (idx)
      1: base = z;
      2: base = c;
      3: base = s;
      4: base = v;
      5: base = c & ~z;
      6: base = (s == v);
      default: base = ~z & (s == v);
    endcase
    return code[0] ? base : ~base;
  endfunction

  task automatic step(input logic v, input logic [2:0] rd, input logic [15:0] res,
                      input logic fwe, input logic [3:0] fl, input logic fsh,
                      input logic [2:0] rs, input logic [2:0] rt, input logic [3:0] cond,
                      input bit do_chk);
    logic [3:0] src;
    i_wb_valid = v; i_wb_rd = rd; i_wb_result = res; i_wb_flags_we = fwe;
    {i_carry, i_overflow, i_zero, i_sign} = fl;
    i_flush = fsh; i_rs_addr = rs; i_rt_addr = rt; i_cond = cond;
    #1;
    if (do_chk) begin
      src = (m_pv && m_pfwe && !fsh) ? m_pfl : m_flags;
      check("rs_data", o_rs_data, m_read(rs));
      check("rt_data", o_rt_data, m_read(rt));
      check("cond", o_cond_true, m_cond(src, cond));
    end
    @(posedge clk);
    if (m_pv && !fsh) begin
      if (m_prd != 3'd0) m_regs[m_prd] = m_pres;
      if (m_pfwe) m_flags = m_pfl;
      m_retired = m_retired + 16'd1;
    end
    m_pv = v; m_prd = rd; m_pres = res; m_pfwe = fwe; m_pfl = fl;
    @(negedge clk);
    if (do_chk) begin
      check("flags", o_flags, m_flags);
      check("retired", o_retired, m_retired);
    end
  endtask

  task automatic peek(input string tag, input logic [2:0] a, input logic [15:0] exp);
    i_wb_valid = 1'b0; i_flush = 1'b0; i_rs_addr = a;
    #1;
    check(tag, o_rs_data, exp);
  endtask

  task automatic idle(input logic [2:0] rs);
    step(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b0, rs, 3'd0, 4'd0, 1'b1);
  endtask

  initial begin
    logic [15:0] zmask;
    logic [15:0] base_ret;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero flags: Z=0 so NE/GT hold, EQ/LE do not
    zmask = 16'h2D55;
    for (int c = 0; c < 16; c++) begin
      i_cond = 4'(c);
      #1;
      check("rst_cond", o_cond_true, zmask[c]);
      step(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b0, 3'(1 + c % 7), 3'(7 - c % 7), 4'(c), 1'b1);
    end
    check("rst_flags", o_flags, 4'h0);
    check("rst_retired", o_retired, 16'h0);

    base_ret = m_retired;
    step(1'b1, 3'd3, 16'h1234, 1'b0, 4'h0, 1'b0, 3'd3, 3'd3, 4'd0, 1'b1);
    idle(3'd3);
    idle(3'd3);
    peek("r3_value", 3'd3, 16'h1234);
    check("r3_retired", o_retired, base_ret + 16'd1);

    step(1'b1, 3'd2, 16'h0001, 1'b0, 4'h0, 1'b0, 3'd2, 3'd2, 4'd0, 1'b1);
    step(1'b1, 3'd2, 16'hFFFF, 1'b0, 4'h0, 1'b0, 3'd2, 3'd2, 4'd0, 1'b1);
    idle(3'd2);
    idle(3'd2);
    peek("r2_final", 3'd2, 16'hFFFF);

    base_ret = m_retired;
    step(1'b1, 3'd5, 16'hAAAA, 1'b1, 4'b1000, 1'b0, 3'd5, 3'd5, 4'd9, 1'b1);
    i_wb_valid = 1'b0; i_flush = 1'b0; i_cond = 4'd9;
    #1;
    check("hi_pending", o_cond_true, 1'b1);
    step(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b1, 3'd5, 3'd5, 4'd9, 1'b1);
    idle(3'd5);
    peek("r5_flushed", 3'd5, 16'h0000);
    check("flush_flags", o_flags, 4'h0);
    check("flush_retired", o_retired, base_ret);

    base_ret = m_retired;
    step(1'b1, 3'd0, 16'h5555, 1'b1, 4'b0110, 1'b0, 3'd0, 3'd0, 4'd0, 1'b1);
    idle(3'd0);
    idle(3'd0);
    peek("r0_zero", 3'd0, 16'h0000);
    check("r0_retired", o_retired, base_ret + 16'd1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(3) != 0), 3'($urandom_range(7)), 16'($urandom),
           1'($urandom_range(1)), 4'($urandom_range(15)), ($urandom_range(7) == 0),
           3'($urandom_range(7)), 3'($urandom_range(7)), 4'($urandom_range(15)), 1'b1);
    end

    // Fill the retire counter to its top value, last write still pending in W1
    while (m_retired != 16'hFFFF) begin
      step(1'b1, 3'($urandom_range(7)), 16'($urandom), 1'b0, 4'h0, 1'b0,
           3'd1, 3'd2, 4'd0, 1'b0);
    end
    check("ret_top", o_retired, 16'hFFFF);
    idle(3'd1);
    check("ret_wrap", o_retired, 16'h0000);

    // Asynchronous reset with a result held in W1
    step(1'b1, 3'd4, 16'hBEEF, 1'b1, 4'b1111, 1'b0, 3'd4, 3'd4, 4'd0, 1'b1);
    i_wb_valid = 1'b0; i_flush = 1'b0; i_rs_addr = 3'd4; i_rt_addr = 3'd6; i_cond = 4'd2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_rs", o_rs_data, 16'h0000);
    check("arst_rt", o_rt_data, 16'h0000);
    check("arst_flags", o_flags, 4'h0);
    check("arst_retired", o_retired, 16'h0000);
    check("arst_cond_ne", o_cond_true, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3'd4);
    idle(3'd4);
    check("post_rst_retired", o_retired, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
